// File: rtl/voq_dequeue_scheduler.sv
// Read-side scheduler for the per-port address queue: round-robin grant of a
// non-empty channel, bursts of up to MAX_BURST pops into a registered valid/ready output.
module voq_dequeue_scheduler #(
  parameter  int PORT_NUB    = 4,
  parameter  int DEPTH       = 100,
  parameter  int MAX_BURST   = 4,
  localparam int WIDTH_PORT  = $clog2(DEPTH),
  localparam int WIDTH_SEL   = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
  localparam int WIDTH_BURST = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic [PORT_NUB-1:0]   fifo_empty,
  input  logic [WIDTH_PORT-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [WIDTH_SEL-1:0]  fifo_rd_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_SEL-1:0]  out_port,
  output logic [WIDTH_PORT-1:0] out_addr
);

  localparam int unsigned NUB_U = PORT_NUB;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e                 state_q;
  logic [WIDTH_SEL-1:0]   rr_ptr_q;
  logic [WIDTH_SEL-1:0]   grant_q;
  logic [WIDTH_BURST-1:0] cnt_q;
  logic                   out_valid_q;
  logic [WIDTH_SEL-1:0]   out_port_q;
  logic [WIDTH_PORT-1:0]  out_addr_q;

  logic                   load_ok;
  logic                   pop;
  logic                   exit_d;
  logic                   hit_d;
  logic [WIDTH_SEL-1:0]   pick_d;
  logic [WIDTH_SEL-1:0]   cand_d;
  logic [WIDTH_SEL-1:0]   grant_nxt;
  int unsigned            idx_d;

  // First non-empty channel at or after rr_ptr, wrapping modulo PORT_NUB.
  always_comb begin
    hit_d  = 1'b0;
    pick_d = '0;
    cand_d = '0;
    idx_d  = 0;
    for (int unsigned i = 0; i < NUB_U; i++) begin
      idx_d = i + rr_ptr_q;
      if (idx_d >= NUB_U) idx_d = idx_d - NUB_U;
      cand_d = WIDTH_SEL'(idx_d);
      if (!hit_d && !fifo_empty[cand_d]) begin
        hit_d  = 1'b1;
        pick_d = cand_d;
      end
    end
  end

  always_comb begin
    load_ok   = ~out_valid_q | out_ready;
    pop       = (state_q == SERVE) & sched_en & ~fifo_empty[grant_q] & load_ok &
                (cnt_q < WIDTH_BURST'(MAX_BURST));
    exit_d    = ~sched_en | (pop & (cnt_q == WIDTH_BURST'(MAX_BURST - 1))) |
                (fifo_empty[grant_q] & ~pop);
    grant_nxt = (grant_q == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_port_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      if (out_valid_q && out_ready && !pop) out_valid_q <= 1'b0;
      if (pop) begin
        out_valid_q <= 1'b1;
        out_port_q  <= grant_q;
        out_addr_q  <= fifo_rd_data;
        cnt_q       <= cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sched_en && hit_d) begin
            grant_q <= pick_d;
            cnt_q   <= '0;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          // Backpressure alone never ends a burst: exit only on limit, empty or disable.
          if (exit_d) begin
            state_q  <= IDLE;
            rr_ptr_q <= grant_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en  = pop;
  assign fifo_rd_sel = (state_q == SERVE) ? grant_q : rr_ptr_q;
  assign out_valid   = out_valid_q;
  assign out_port    = out_port_q;
  assign out_addr    = out_addr_q;

endmodule

// File: tb/tb_voq_dequeue_scheduler.sv
// Bench for voq_dequeue_scheduler: behavioural FIFO, cycle reference model,
// per-channel scoreboard, directed scenarios and a randomized soak.
module tb_voq_dequeue_scheduler;

  localparam int NUB = 4;
  localparam int DEP = 100;
  localparam int MB  = 4;
  localparam int AW  = 7;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sched_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [NUB-1:0] fifo_empty;
  logic [AW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [SW-1:0] fifo_rd_sel;
  logic          out_valid;
  logic [SW-1:0] out_port;
  logic [AW-1:0] out_addr;

  logic          push_v = 1'b0;
  logic [SW-1:0] push_ch = '0;
  logic [AW-1:0] push_dat = '0;

  always #5 clk = ~clk;

  voq_dequeue_scheduler #(.PORT_NUB(NUB), .DEPTH(DEP), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_sel(fifo_rd_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_addr(out_addr)
  );

  // Second instance, single-pop bursts, fed by a fixed two-entry-per-channel source.
  logic          rr_en = 1'b0;
  logic          rr_ready = 1'b1;
  logic [NUB-1:0] rr_empty;
  logic [1:0]    rr_cnt [NUB];
  logic [AW-1:0] rr_data;
  logic          rr_rd;
  logic [SW-1:0] rr_sel;
  logic          rr_v;
  logic [SW-1:0] rr_port;
  logic [AW-1:0] rr_addr;

  voq_dequeue_scheduler #(.PORT_NUB(NUB), .DEPTH(DEP), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .sched_en(rr_en),
    .fifo_empty(rr_empty), .fifo_rd_data(rr_data),
    .fifo_rd_en(rr_rd), .fifo_rd_sel(rr_sel),
    .out_valid(rr_v), .out_ready(rr_ready),
    .out_port(rr_port), .out_addr(rr_addr)
  );

  assign rr_data = {rr_sel, rr_cnt[rr_sel], 3'b101};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUB; c++) rr_cnt[c] <= 2'd2;
      rr_empty <= '0;
    end else begin
      for (int c = 0; c < NUB; c++) begin
        if (rr_rd && rr_sel == c[1:0] && rr_cnt[c] != 2'd0) begin
          rr_cnt[c]   <= rr_cnt[c] - 2'd1;
          rr_empty[c] <= (rr_cnt[c] == 2'd1);
        end
      end
    end
  end

  // Behavioural multi-channel FIFO: empty flags registered, head read combinational.
  logic [AW-1:0] mem [NUB][256];
  logic [7:0]    hd [NUB];
  logic [7:0]    tl [NUB];

  function automatic bit pop_hit(input int c);
    return fifo_rd_en && fifo_rd_sel == 2'(c) && hd[c] != tl[c];
  endfunction

  function automatic bit push_hit(input int c);
    return push_v && push_ch == 2'(c);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUB; c++) begin
        hd[c] <= '0;
        tl[c] <= '0;
      end
      fifo_empty <= '1;
    end else begin
      for (int c = 0; c < NUB; c++) begin
        if (pop_hit(c)) hd[c] <= hd[c] + 8'd1;
        if (push_hit(c)) begin
          mem[c][tl[c]] <= push_dat;
          tl[c] <= tl[c] + 8'd1;
        end
        fifo_empty[c] <= (hd[c] + 8'(pop_hit(c))) == (tl[c] + 8'(push_hit(c)));
      end
    end
  end

  assign fifo_rd_data = mem[fifo_rd_sel][hd[fifo_rd_sel]];

  // Reference model: arbitration and burst rules in plain arithmetic.
  bit            m_serve;
  logic [SW-1:0] m_ch;
  logic [SW-1:0] m_ptr;
  int            m_n;
  logic          m_ov;
  logic [SW-1:0] m_op;
  logic [AW-1:0] m_oa;

  function automatic bit m_pop();
    return m_serve && sched_en && !fifo_empty[m_ch] && (!m_ov || out_ready) && m_n < MB;
  endfunction

  function automatic int m_pick();
    logic [SW-1:0] c;
    for (int i = 0; i < NUB; i++) begin
      c = 2'((int'(m_ptr) + i) % NUB);
      if (!fifo_empty[c]) return int'(c);
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_serve <= 1'b0; m_ch <= '0; m_ptr <= '0; m_n <= 0;
      m_ov <= 1'b0; m_op <= '0; m_oa <= '0;
    end else begin
      if (m_ov && out_ready && !m_pop()) m_ov <= 1'b0;
      if (m_pop()) begin
        m_ov <= 1'b1;
        m_op <= m_ch;
        m_oa <= mem[m_ch][hd[m_ch]];
        m_n  <= m_n + 1;
      end
      if (!m_serve) begin
        if (sched_en && m_pick() >= 0) begin
          m_ch    <= 2'(m_pick());
          m_n     <= 0;
          m_serve <= 1'b1;
        end
      end else if (!sched_en || (m_pop() && m_n + 1 == MB) || (fifo_empty[m_ch] && !m_pop())) begin
        m_serve <= 1'b0;
        m_ptr   <= 2'((int'(m_ch) + 1) % NUB);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, scoreboard and logs.
  logic [AW-1:0] sb [NUB][$];
  logic [AW-1:0] hs_addr [$];
  logic [SW-1:0] hs_port [$];
  int            hs_cyc [$];
  logic [SW-1:0] rr_seq_p [$];
  logic [AW-1:0] rr_seq_a [$];
  int            cyc = 0;
  int            n_rden = 0;
  int            n_valid = 0;
  logic [SW-1:0] last_sel = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUB; c++) sb[c].delete();
    end else begin
      chk("rd_en", 32'(fifo_rd_en), 32'(m_pop()));
      chk("rd_sel", 32'(fifo_rd_sel), 32'(m_serve ? m_ch : m_ptr));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_port", 32'(out_port), 32'(m_op));
      chk("out_addr", 32'(out_addr), 32'(m_oa));
      if (out_valid && out_ready) begin
        checks++;
        if (sb[out_port].size() == 0) begin
          errors++;
          $display("FAIL sb_extra actual=%0h required=none at %0t", out_addr, $time);
        end else if (out_addr !== sb[out_port][0]) begin
          errors++;
          $display("FAIL sb_order actual=%0h required=%0h at %0t", out_addr, sb[out_port][0], $time);
          void'(sb[out_port].pop_front());
        end else begin
          void'(sb[out_port].pop_front());
        end
        hs_addr.push_back(out_addr);
        hs_port.push_back(out_port);
        hs_cyc.push_back(cyc);
      end
      if (push_v) sb[push_ch].push_back(push_dat);
      if (fifo_rd_en) begin
        n_rden++;
        last_sel = fifo_rd_sel;
      end
      if (out_valid) n_valid++;
      if (rr_v && rr_ready) begin
        rr_seq_p.push_back(rr_port);
        rr_seq_a.push_back(rr_addr);
      end
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; sched_en = 1'b0; out_ready = 1'b0; push_v = 1'b0; rr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input int ch, input logic [AW-1:0] d);
    push_v = 1'b1; push_ch = 2'(ch); push_dat = d;
    @(posedge clk);
    #1 push_v = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int t = 0; t < 30 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  int b0, r0, v0, tot;
  logic [AW-1:0] e7;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_port", 32'(out_port), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_rd_sel", 32'(fifo_rd_sel), 0);

    // Round robin with single-pop bursts, channel 3 wraps to 0.
    @(posedge clk); #1 rr_en = 1'b1;
    repeat (30) @(posedge clk);
    #1 rr_en = 1'b0;
    chk("rr_count", 32'(rr_seq_p.size()), 8);
    for (int i = 0; i < 8 && i < rr_seq_p.size(); i++) begin
      e7 = {2'(i % 4), 2'(2 - i / 4), 3'b101};
      chk("rr_port", 32'(rr_seq_p[i]), 32'(i % 4));
      chk("rr_addr", 32'(rr_seq_a[i]), 32'(e7));
    end

    // Single entry in channel 1.
    b0 = hs_addr.size(); r0 = n_rden; v0 = n_valid;
    sched_en = 1'b1; out_ready = 1'b1;
    push(1, 7'h2A);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("single_pops", 32'(n_rden - r0), 1);
    chk("single_pop_sel", 32'(last_sel), 1);
    chk("single_valid_cycles", 32'(n_valid - v0), 1);
    chk("single_hs", 32'(hs_addr.size() - b0), 1);
    if (hs_addr.size() > b0) begin
      chk("single_addr", 32'(hs_addr[b0]), 32'h2A);
      chk("single_port", 32'(hs_port[b0]), 1);
    end
    chk("single_rr_ptr", 32'(fifo_rd_sel), 2);

    // Burst limit on channel 0.
    @(posedge clk); #1 sched_en = 1'b0;
    for (int i = 0; i < 6; i++) push(0, 7'(8'h10 + i));
    b0 = hs_addr.size();
    sched_en = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("burst_hs", 32'(hs_addr.size() - b0), 6);
    if (hs_addr.size() >= b0 + 6) begin
      for (int i = 0; i < 6; i++) chk("burst_addr", 32'(hs_addr[b0 + i]), 32'(8'h10 + i));
      for (int i = 1; i < 6; i++)
        chk("burst_gap", 32'(hs_cyc[b0 + i] - hs_cyc[b0 + i - 1]), (i == 4) ? 2 : 1);
    end

    // Backpressure mid-burst on channel 2.
    sched_en = 1'b0;
    for (int i = 0; i < 4; i++) push(2, 7'(8'h30 + i));
    b0 = hs_addr.size();
    sched_en = 1'b1; out_ready = 1'b1;
    wait_valid("bp_first_valid");
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_addr", 32'(out_addr), 32'h30);
      chk("bp_port", 32'(out_port), 2);
      chk("bp_no_pop", 32'(fifo_rd_en), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_hs", 32'(hs_addr.size() - b0), 4);
    if (hs_addr.size() >= b0 + 4)
      for (int i = 0; i < 4; i++) chk("bp_order", 32'(hs_addr[b0 + i]), 32'(8'h30 + i));

    // Enable drop mid-burst on channel 3.
    sched_en = 1'b0;
    for (int i = 0; i < 3; i++) push(3, 7'(8'h40 + i));
    b0 = hs_addr.size();
    sched_en = 1'b1; out_ready = 1'b1;
    wait_valid("en_first_valid");
    sched_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("en_no_pop", 32'(fifo_rd_en), 0);
    chk("en_hold_addr", 32'(out_addr), 32'h40);
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_idle_sel", 32'(fifo_rd_sel), 0);
    chk("en_idle_no_pop", 32'(fifo_rd_en), 0);
    chk("en_still_valid", 32'(out_valid), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("en_drained", 32'(out_valid), 0);
    chk("en_hs", 32'(hs_addr.size() - b0), 1);
    if (hs_addr.size() > b0) chk("en_hs_addr", 32'(hs_addr[b0]), 32'h40);

    // Reset while holding an entry.
    sched_en = 1'b1; out_ready = 1'b0;
    wait_valid("rst_hold_valid");
    chk("rst_hold_addr", 32'(out_addr), 32'h41);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_port", 32'(out_port), 0);
    chk("midrst_addr", 32'(out_addr), 0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 0);
    chk("midrst_rd_sel", 32'(fifo_rd_sel), 0);
    do_reset();

    // Randomized soak against the reference model and scoreboard.
    for (int n = 0; n < 3000; n++) begin
      sched_en  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      push_ch   = 2'($urandom_range(0, NUB - 1));
      push_dat  = 7'($urandom);
      push_v    = ($urandom_range(0, 1) == 1) && (8'(tl[push_ch] - hd[push_ch]) < 8'd200);
      @(posedge clk);
      #1;
    end
    push_v = 1'b0; sched_en = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 800 && !(fifo_empty == '1 && !out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("soak_drained_valid", 32'(out_valid), 0);
    chk("soak_drained_fifo", 32'(fifo_empty), 32'hF);
    tot = 0;
    for (int c = 0; c < NUB; c++) tot += sb[c].size();
    chk("soak_sb_left", 32'(tot), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
